// File: rtl/led_sweep_pkg.sv
// ----------------------------------------------------------------------------
// led_sweep_pkg
// Shared types and board defaults for the front-panel LED sweep sequencer.
//   state_t      : sweep FSM states (IDLE, UP, DOWN, HOLD)
//   DIR_UP/DOWN  : encoding of the dir output
//   BOARD_*      : default bar width and step divider for the board
// ----------------------------------------------------------------------------
package led_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int BOARD_N_LEDS = 14;
  localparam int BOARD_DIV    = 1000000;
  localparam int BOARD_CNT_W  = 20;
  localparam int BOARD_POS_W  = 4;

endpackage

// File: rtl/step_tick_gen.sv
// ----------------------------------------------------------------------------
// step_tick_gen
// Single-clock step-rate divider. Counts enabled cycles 0..DIV-1 and raises
// tick combinationally on the last count, so the consumer advances on the
// same edge the counter wraps. No derived clock leaves this block.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   en    in  count enable (counter holds when low)
//   clr   in  synchronous clear of the counter, wins over en/tick
//   tick  out high during the cycle whose edge completes a step period
// ----------------------------------------------------------------------------
module step_tick_gen
  import led_sweep_pkg::*;
#(
  parameter int DIV   = BOARD_DIV,
  parameter int CNT_W = BOARD_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // With DIV=1 LAST_CNT is 0, so tick follows en every cycle.
  assign tick = en && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// led_sweep_ctrl
// LED light-bar sweep sequencer. Walks a single lit LED across the bar at a
// rate set by step_tick_gen, bouncing at the ends or wrapping around.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset (priority over clear)
//   run     in  level: 1 = sweep advances, 0 = freeze (HOLD)
//   clear   in  pulse: abort and return to IDLE (priority over run/tick)
//   wrap    in  0 = bounce at ends, 1 = wrap (sampled at ends on a tick)
//   led_reg out one-hot LED drive, all-zero in IDLE
//   dir     out 0 = moving up, 1 = moving down
//   pos     out index of the lit LED
//   step    out one-cycle pulse the cycle after pos advanced
// ----------------------------------------------------------------------------
module led_sweep_ctrl
  import led_sweep_pkg::*;
#(
  parameter int N_LEDS = BOARD_N_LEDS,
  parameter int DIV    = BOARD_DIV,
  parameter int CNT_W  = BOARD_CNT_W,
  parameter int POS_W  = BOARD_POS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear,
  input  logic              wrap,
  output logic [N_LEDS-1:0] led_reg,
  output logic              dir,
  output logic [POS_W-1:0]  pos,
  output logic              step
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] PREV_POS = POS_W'(N_LEDS - 2);

  state_t              r_state;
  logic [POS_W-1:0]    r_pos;
  logic                r_dir;
  logic [N_LEDS-1:0]   r_led;
  logic                r_step;

  state_t              w_state_next;
  logic [POS_W-1:0]    w_pos_next;
  logic                w_dir_next;
  logic [N_LEDS-1:0]   w_led_next;
  logic                w_step_next;

  logic                w_tick_en;
  logic                w_tick_clr;
  logic                w_tick;

  // Divider only runs while actively sweeping; it is held at zero in IDLE so
  // every sweep starts with a full step period on LED 0.
  assign w_tick_en  = run && ((r_state == UP) || (r_state == DOWN));
  assign w_tick_clr = clear || (r_state == IDLE);

  step_tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_step_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_tick_en),
    .clr   (w_tick_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_dir   <= DIR_UP;
      r_led   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
      r_dir   <= w_dir_next;
      r_led   <= w_led_next;
      r_step  <= w_step_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_dir_next   = r_dir;
    w_step_next  = 1'b0;

    if (clear) begin
      w_state_next = IDLE;
      w_pos_next   = '0;
      w_dir_next   = DIR_UP;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (run) begin
            w_state_next = UP;
            w_pos_next   = '0;
            w_dir_next   = DIR_UP;
          end
        end
        UP: begin
          if (!run) begin
            w_state_next = HOLD;
          end else if (w_tick) begin
            w_step_next = 1'b1;
            if (r_pos != LAST_POS) begin
              w_pos_next = r_pos + POS_W'(1);
            end else if (!wrap) begin
              w_state_next = DOWN;
              w_dir_next   = DIR_DOWN;
              w_pos_next   = PREV_POS;
            end else begin
              w_pos_next = '0;
            end
          end
        end
        DOWN: begin
          if (!run) begin
            w_state_next = HOLD;
          end else if (w_tick) begin
            w_step_next = 1'b1;
            if (r_pos != '0) begin
              w_pos_next = r_pos - POS_W'(1);
            end else if (!wrap) begin
              w_state_next = UP;
              w_dir_next   = DIR_UP;
              w_pos_next   = POS_W'(1);
            end else begin
              w_pos_next = LAST_POS;
            end
          end
        end
        HOLD: begin
          // Resume in the frozen direction; the divider keeps its count.
          if (run) begin
            w_state_next = (r_dir == DIR_DOWN) ? DOWN : UP;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // LED decode from the next position keeps led_reg aligned with pos.
  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
    assign w_led_next[gi] = (w_state_next != IDLE) && (w_pos_next == POS_W'(gi));
  end

  assign led_reg = r_led;
  assign dir     = r_dir;
  assign pos     = r_pos;
  assign step    = r_step;

endmodule
